// File: rtl/elevator_call_scheduler_if.sv
// Signal bundle between the elevator call scheduler (master) and the button/floor-counter side (slave).
// With ESTOP_EN defined, the bundle also carries the active-high emergency stop input.
interface elevator_call_scheduler_if #(
    parameter int N_FLOORS = 8
);
    logic [N_FLOORS-1:0] call_req;
    logic [7:0]          floor_q;
    logic                run;
    logic                dir_up;
    logic [7:0]          min_floor;
    logic [7:0]          max_floor;
    logic                door_open;
    logic [N_FLOORS-1:0] pending;
    logic                busy;
    logic [2:0]          dbg_state;
`ifdef ESTOP_EN
    logic                estop;
`endif

    // No valid/ready handshake: call_req is level-sampled every cycle and run is a one-cycle step strobe.
    modport master (
`ifdef ESTOP_EN
        input  estop,
`endif
        input  call_req, floor_q,
        output run, dir_up, min_floor, max_floor, door_open, pending, busy, dbg_state
    );

    modport slave (
`ifdef ESTOP_EN
        output estop,
`endif
        output call_req, floor_q,
        input  run, dir_up, min_floor, max_floor, door_open, pending, busy, dbg_state
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN-style elevator call scheduler: latches calls, steps the floor counter, holds the door per stop.
// Optional macro ESTOP_EN adds an estop input and a HALT state.
module elevator_call_scheduler #(
    parameter int N_FLOORS    = 8,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    elevator_call_scheduler_if.master   bus
);
    localparam int             TW        = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0]  DOOR_LOAD = TW'(DOOR_CYCLES);
    localparam logic [7:0]     TOP_FLOOR = 8'(N_FLOORS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_CHECK = 3'd2,
        S_DOOR  = 3'd3
`ifdef ESTOP_EN
        , S_HALT = 3'd4
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_dir_up;
    logic                w_dir_nxt;
    logic [N_FLOORS-1:0] r_pending;
    logic [N_FLOORS-1:0] w_pending_nxt;
    logic [TW-1:0]       r_timer;
    logic [TW-1:0]       w_timer_nxt;
    logic [N_FLOORS-1:0] w_floor_hot;
    logic [N_FLOORS-1:0] w_absorb_mask;
    logic [N_FLOORS-1:0] w_clear_mask;
    logic                w_above;
    logic                w_below;
    logic                w_here;
    logic                w_absorb;
    logic                w_enter_door;

    // An out-of-range floor_q matches no bit, so every pending call counts as below it.
    always_comb begin
        w_floor_hot = '0;
        w_above     = 1'b0;
        w_below     = 1'b0;
        w_here      = 1'b0;
        for (int f = 0; f < N_FLOORS; f++) begin
            w_floor_hot[f] = (8'(f) == bus.floor_q);
            if (r_pending[f]) begin
                if (8'(f) > bus.floor_q)  w_above = 1'b1;
                if (8'(f) < bus.floor_q)  w_below = 1'b1;
                if (8'(f) == bus.floor_q) w_here  = 1'b1;
            end
        end
    end

    assign w_absorb_mask = (r_state == S_DOOR) ? w_floor_hot : '0;
    assign w_absorb      = |(bus.call_req & w_absorb_mask);
    assign w_enter_door  = (w_state_nxt == S_DOOR) && (r_state != S_DOOR);
    assign w_clear_mask  = w_enter_door ? w_floor_hot : '0;
    // Clear beats a same-cycle call for the floor being served.
    assign w_pending_nxt = (r_pending | (bus.call_req & ~w_absorb_mask)) & ~w_clear_mask;

    always_comb begin
        w_timer_nxt = r_timer;
        if (w_enter_door || w_absorb) begin
            w_timer_nxt = DOOR_LOAD;
        end else if ((r_state == S_DOOR) && (r_timer != '0)) begin
            w_timer_nxt = r_timer - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_dir_up  <= 1'b1;
            r_pending <= '0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir_up  <= w_dir_nxt;
            r_pending <= w_pending_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir_up;
        case (r_state)
            S_IDLE: begin
                if (w_here) begin
                    w_state_nxt = S_DOOR;
                end else if ((r_dir_up && w_above) || (!r_dir_up && w_below)) begin
                    w_state_nxt = S_STEP;
                end else if (w_above) begin
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = S_STEP;
                end else if (w_below) begin
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_here) begin
                    w_state_nxt = S_DOOR;
                end else if (r_dir_up ? w_above : w_below) begin
                    w_state_nxt = S_STEP;
                end else if (r_dir_up ? w_below : w_above) begin
                    w_dir_nxt   = !r_dir_up;
                    w_state_nxt = S_STEP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DOOR: begin
                if (!w_absorb && (r_timer <= TW'(1))) w_state_nxt = S_IDLE;
            end
`ifdef ESTOP_EN
            S_HALT: begin
                if (!bus.estop) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef ESTOP_EN
        if (bus.estop) begin
            w_state_nxt = S_HALT;
            w_dir_nxt   = r_dir_up;
        end
`endif
    end

    always_comb begin
        bus.run       = (r_state == S_STEP);
        bus.door_open = (r_state == S_DOOR);
        bus.busy      = (r_state != S_IDLE);
        bus.dir_up    = r_dir_up;
        bus.pending   = r_pending;
        bus.min_floor = 8'd0;
        bus.max_floor = TOP_FLOOR;
        bus.dbg_state = r_state;
    end
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler with a saturating floor-counter model.
// Define ESTOP_EN to also exercise the emergency-stop path.
module tb_elevator_call_scheduler;
    localparam int N  = 8;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elevator_call_scheduler_if #(.N_FLOORS(N)) bus();
    elevator_call_scheduler #(.N_FLOORS(N), .DOOR_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] model_q;
    logic       q_force;
    logic [7:0] q_force_val;
    assign bus.floor_q = model_q;

    // Floor counter model: steps on run, saturates at 0 and N-1; q_force loads a floor directly.
    always @(posedge clk) begin
        if (q_force) model_q <= q_force_val;
        else if (bus.run === 1'b1) begin
            if (bus.dir_up) begin
                if (model_q < 8'(N - 1)) model_q <= model_q + 8'd1;
            end else if (model_q > 8'd0) model_q <= model_q - 8'd1;
        end
    end

    int n_pass = 0;
    int n_total = 0;
    int n_runs, n_up, gap_bad;
    int guard_bad = 0;
    logic [31:0] stops, lens;
    logic [N-1:0] door_pend;
    bit done;

    task automatic reset_at(input logic [7:0] f);
        @(negedge clk);
        rst = 1'b0; q_force = 1'b1; q_force_val = f; bus.call_req = '0;
        @(negedge clk);
        rst = 1'b1; q_force = 1'b0;
    endtask

    task automatic pulse_call(input logic [N-1:0] m);
        @(negedge clk); bus.call_req = m;
        @(negedge clk); bus.call_req = '0;
    endtask

    // Runs until idle with nothing pending; trig_kind 1 injects at floor trig_val, 2 on door cycle trig_val.
    task automatic observe(input int max_cyc, input int trig_kind, input logic [7:0] trig_val, input logic [N-1:0] inj);
        int door_len, last_run;
        bit fired;
        stops = '0; lens = '0; n_runs = 0; n_up = 0; gap_bad = 0; door_pend = '0;
        done = 0; door_len = 0; last_run = -1; fired = 0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            bus.call_req = '0;
            if (bus.run === 1'b1) begin
                n_runs++;
                if (bus.dir_up) n_up++;
                if (last_run >= 0 && cyc - last_run != 2) gap_bad++;
                last_run = cyc;
                if ((bus.dir_up && model_q == 8'(N - 1)) || (!bus.dir_up && model_q == 8'd0)) guard_bad++;
            end
            if (bus.door_open === 1'b1) begin
                if (door_len == 0) stops = {stops[23:0], model_q};
                door_len++;
                door_pend |= bus.pending;
                if (!fired && trig_kind == 2 && door_len == int'(trig_val)) begin bus.call_req = inj; fired = 1; end
            end else if (door_len != 0) begin
                lens = {lens[23:0], 8'(door_len)};
                door_len = 0;
            end
            if (!fired && trig_kind == 1 && model_q == trig_val && bus.busy) begin bus.call_req = inj; fired = 1; end
            if (!bus.busy && bus.pending == '0 && door_len == 0) begin done = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; q_force = 1'b1; q_force_val = 8'd0; bus.call_req = '0;
`ifdef ESTOP_EN
        bus.estop = 1'b0;
`endif
        @(negedge clk);
        n_total++; if (bus.run !== 1'b0) $display("FAIL reset_run: got %b expected 0", bus.run); else n_pass++;
        n_total++; if (bus.door_open !== 1'b0) $display("FAIL reset_door: got %b expected 0", bus.door_open); else n_pass++;
        n_total++; if (bus.pending !== 8'h00) $display("FAIL reset_pending: got %h expected 00", bus.pending); else n_pass++;
        n_total++; if (bus.dir_up !== 1'b1) $display("FAIL reset_dir: got %b expected 1", bus.dir_up); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
        n_total++; if (bus.max_floor !== 8'd7 || bus.min_floor !== 8'd0) $display("FAIL range_consts: got %0d..%0d expected 0..7", bus.min_floor, bus.max_floor); else n_pass++;
        rst = 1'b1; q_force = 1'b0;
    endtask

    task automatic test_single_call();
        reset_at(8'd0);
        pulse_call(8'h20);
        n_total++; if (bus.pending !== 8'h20) $display("FAIL s1_latch: got %h expected 20", bus.pending); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL s1_latch_delay: got busy %b expected 0", bus.busy); else n_pass++;
        observe(200, 0, 8'd0, '0);
        n_total++; if (!done) $display("FAIL s1_timeout: got not idle expected idle"); else n_pass++;
        n_total++; if (n_runs != 5 || n_up != 5) $display("FAIL s1_runs: got %0d (%0d up) expected 5 (5 up)", n_runs, n_up); else n_pass++;
        n_total++; if (gap_bad != 0) $display("FAIL s1_spacing: got %0d bad gaps expected 0", gap_bad); else n_pass++;
        n_total++; if (stops !== 32'h05) $display("FAIL s1_stops: got %h expected 00000005", stops); else n_pass++;
        n_total++; if (lens !== 32'h04) $display("FAIL s1_door_len: got %h expected 00000004", lens); else n_pass++;
        n_total++; if (bus.pending !== 8'h00 || bus.busy !== 1'b0) $display("FAIL s1_final: got pending %h busy %b expected 00 0", bus.pending, bus.busy); else n_pass++;
    endtask

    task automatic test_two_directions();
        reset_at(8'd3);
        pulse_call(8'h41);
        observe(300, 0, 8'd0, '0);
        n_total++; if (!done) $display("FAIL s2_timeout: got not idle expected idle"); else n_pass++;
        n_total++; if (stops !== 32'h0600) $display("FAIL s2_stops: got %h expected 00000600", stops); else n_pass++;
        n_total++; if (lens !== 32'h0404) $display("FAIL s2_door_lens: got %h expected 00000404", lens); else n_pass++;
        n_total++; if (n_runs != 9 || n_up != 3) $display("FAIL s2_runs: got %0d (%0d up) expected 9 (3 up)", n_runs, n_up); else n_pass++;
        n_total++; if (bus.dir_up !== 1'b0) $display("FAIL s2_dir: got %b expected 0", bus.dir_up); else n_pass++;
    endtask

    task automatic test_call_en_route();
        reset_at(8'd0);
        pulse_call(8'h40);
        observe(400, 1, 8'd2, 8'h12);
        n_total++; if (!done) $display("FAIL s3_timeout: got not idle expected idle"); else n_pass++;
        n_total++; if (stops !== 32'h040601) $display("FAIL s3_stops: got %h expected 00040601", stops); else n_pass++;
        n_total++; if (n_runs != 11 || n_up != 6) $display("FAIL s3_runs: got %0d (%0d up) expected 11 (6 up)", n_runs, n_up); else n_pass++;
        n_total++; if (lens !== 32'h040404) $display("FAIL s3_door_lens: got %h expected 00040404", lens); else n_pass++;
    endtask

    task automatic test_door_extend();
        reset_at(8'd0);
        pulse_call(8'h04);
        observe(200, 2, 8'd3, 8'h04);
        n_total++; if (!done) $display("FAIL s4_timeout: got not idle expected idle"); else n_pass++;
        n_total++; if (stops !== 32'h02) $display("FAIL s4_stops: got %h expected 00000002", stops); else n_pass++;
        n_total++; if (lens !== 32'h07) $display("FAIL s4_door_len: got %h expected 00000007", lens); else n_pass++;
        n_total++; if ((door_pend & 8'h04) !== 8'h00) $display("FAIL s4_absorb: got pending %h during door expected bit2 clear", door_pend); else n_pass++;
    endtask

    task automatic test_bad_floor_and_top();
        reset_at(8'd9);
        pulse_call(8'h80);
        observe(200, 0, 8'd0, '0);
        n_total++; if (!done) $display("FAIL s5_timeout: got not idle expected idle"); else n_pass++;
        n_total++; if (n_runs != 2 || n_up != 0) $display("FAIL s5_runs: got %0d (%0d up) expected 2 (0 up)", n_runs, n_up); else n_pass++;
        n_total++; if (stops !== 32'h07 || lens !== 32'h04) $display("FAIL s5_stop: got %h/%h expected 00000007/00000004", stops, lens); else n_pass++;
        pulse_call(8'h80);
        observe(100, 0, 8'd0, '0);
        n_total++; if (n_runs != 0 || stops !== 32'h07) $display("FAIL s5_here_call: got %0d runs stops %h expected 0 runs 00000007", n_runs, stops); else n_pass++;
    endtask

    task automatic test_reset_mid_move();
        bit found;
        int extra;
        reset_at(8'd2);
        pulse_call(8'h80);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.run === 1'b1 && model_q == 8'd4) begin found = 1; break; end
        end
        n_total++; if (!found) $display("FAIL s6_reach4: got not reached expected run at floor 4"); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (bus.run !== 1'b0 || bus.busy !== 1'b0) $display("FAIL s6_async: got run %b busy %b expected 0 0", bus.run, bus.busy); else n_pass++;
        n_total++; if (bus.pending !== 8'h00) $display("FAIL s6_pending: got %h expected 00", bus.pending); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.run === 1'b1) extra++;
        end
        n_total++; if (extra != 0 || model_q != 8'd4) $display("FAIL s6_parked: got %0d runs floor %0d expected 0 runs floor 4", extra, model_q); else n_pass++;
    endtask

`ifdef ESTOP_EN
    task automatic test_estop();
        bit found;
        int extra;
        reset_at(8'd0);
        pulse_call(8'h40);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.run === 1'b1 && model_q == 8'd3) begin found = 1; break; end
        end
        n_total++; if (!found) $display("FAIL es_reach3: got not reached expected run at floor 3"); else n_pass++;
        bus.estop = 1'b1;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.run === 1'b1 || bus.door_open === 1'b1) extra++;
        end
        n_total++; if (extra != 0) $display("FAIL es_halt: got %0d active cycles expected 0", extra); else n_pass++;
        n_total++; if (bus.pending !== 8'h40 || bus.busy !== 1'b1) $display("FAIL es_retain: got pending %h busy %b expected 40 1", bus.pending, bus.busy); else n_pass++;
        bus.estop = 1'b0;
        observe(200, 0, 8'd0, '0);
        n_total++; if (!done || stops !== 32'h06) $display("FAIL es_resume: got done %b stops %h expected 1 00000006", done, stops); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_call();
        test_two_directions();
        test_call_en_route();
        test_door_extend();
        test_bad_floor_and_top();
        test_reset_mid_move();
`ifdef ESTOP_EN
        test_estop();
`endif
        n_total++; if (guard_bad != 0) $display("FAIL range_guard: got %0d bad runs expected 0", guard_bad); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Collective (SCAN-style) scheduler for the elevator floor counter. Latches hall/cab call buttons and drives the counter's step, direction and range inputs one floor at a time. Reads back the current floor, opens the door at each requested floor, and then services the next call. Sits between the button-input logic and the floor counter (outputs run/dir_up/min_floor/max_floor feed the counter's sel/mode/min/max; its q feeds floor_q).

Parameters:
N_FLOORS, 8, number of floors; valid floors 0..N_FLOORS-1 (2..256)
DOOR_CYCLES, 4, clock cycles door_open is held per stop (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
call_req  in  N_FLOORS  call buttons, bit f = request floor f; level or pulse, sampled every cycle
floor_q  in  8  current floor from counter
run  out  1  counter step enable (to sel); one-cycle pulse per floor
dir_up  out  1  counter direction (to mode); 1 = up
min_floor  out  8  constant 0
max_floor  out  8  constant N_FLOORS-1
door_open  out  1  door open at floor_q
pending  out  N_FLOORS  latched, unserved calls
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=0): state IDLE, pending=0, dir_up=1, run=0, door_open=0, timer=0. Reset mid-move drops all calls and parks in IDLE; floor_q is not reset by this block.
- Call latch: pending[f] <= 1 at the edge where call_req[f]=1. Exception: call_req[floor_q] while in DOOR is absorbed (not latched) and reloads timer to DOOR_CYCLES.
- Decisions use the pending register only, so a call first influences the FSM one cycle after it is latched. above = any pending bit > floor_q; below = any pending bit < floor_q.
- States (Moore outputs):
  - IDLE: if pending[floor_q] -> DOOR. Else if dir_up and above -> STEP. Else if !dir_up and below -> STEP. Else if above -> dir_up<=1, STEP. Else if below -> dir_up<=0, STEP. Else stay.
  - STEP: run=1 for exactly one cycle; next state CHECK. The counter updates floor_q at the same edge.
  - CHECK: if pending[floor_q] -> DOOR. Else if a call exists in the current direction -> STEP. Else if a call exists in the opposite direction -> flip dir_up, STEP. Else IDLE.
  - DOOR: door_open=1; on entry clear pending[floor_q] and load timer=DOOR_CYCLES. Decrement each cycle; when timer reaches 1, go to IDLE. Door is open exactly DOOR_CYCLES cycles unless extended.
- Latency: one floor per 2 cycles (STEP+CHECK).
- Range guard: run is never asserted with dir_up=1 at floor_q=N_FLOORS-1, nor with dir_up=0 at floor_q=0.
- floor_q >= N_FLOORS (counter fault): treat as no calls at or above that floor and no door opening; the FSM steps down toward valid calls.
- Simultaneous call and clear of the same bit at DOOR entry: clear wins.
- dir_up changes only in IDLE or CHECK, never in the same cycle as run=1.

Optional Feature:
ESTOP_EN: adds input estop (1 bit, active high).
- With the macro: estop=1 moves any state to HALT at the next edge. In HALT, run=0 and door_open=0; pending is kept and calls are still latched. On estop=0, go to IDLE.
- Without the macro: no port and no HALT state.

Test Plan:
- Bench models the counter (q+1 on run&dir_up, q-1 on run&!dir_up, saturating at min/max).
- Reset at floor 0, 1-cycle call_req=8'h20 -> pending=8'h20; five run pulses with dir_up=1, two cycles apart; door_open high exactly 4 cycles with floor_q=5; then pending=0 and busy=0.
- At floor 3 idle, calls 8'h41 (floors 0 and 6) in the same cycle -> dir_up stays 1; stops at 6 first, then dir_up=0 and travels to 0; two door periods in total.
- Moving up from 0 toward 6, call floor 4 injected while floor_q=2 -> stops at 4 before 6; the call to floor 1 made during this trip is served only after 6.
- Door open at floor 2: call_req=8'h04 on the 3rd door cycle -> door_open extended to 3+4=7 cycles total; pending[2] never set.
- rst pulsed low while floor_q=4 moving to 7 -> immediately run=0, pending=0, IDLE; no further steps.
- ESTOP_EN build: estop=1 mid-move at floor 3 -> HALT, run=0, pending retained; release -> resumes and reaches the target.
